mux4_arbiter: RTL
=================

MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, setting the width of each requester data word.
REQ-002 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  4  request per requester; bit i belongs to requester i.
REQ-006 data0, data1, data2, data3  input  DATA_W each  data word offered by requesters 0..3.
REQ-007 ack  output  4  one-hot, one-cycle pulse; ack[i] means requester i's word was captured.
REQ-008 sel  output  2  index of the requester whose word is in the output register; drives the downstream mux4 select.
REQ-009 out_data  output  DATA_W  registered captured word.
REQ-010 out_valid  output  1  out_data holds a word not yet accepted.
REQ-011 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.

Function
REQ-012 The module SHALL have exactly two states: IDLE (output register empty) and FULL (output register holds a word).
REQ-013 A load SHALL occur on a rising edge when req is nonzero and the module is in IDLE, or the module is in FULL with out_ready high.
REQ-014 On a load, the module SHALL pick a winner index w, set out_data to data_w, sel to w, out_valid to 1, and ack to one-hot(w) for that cycle only.
REQ-015 Round-robin selection: search starts at (ptr+1) mod 4 and proceeds upward with wrap; the first index with req set wins; ptr then becomes w.
REQ-016 In FULL, out_ready low SHALL hold out_data, sel, out_valid and ptr, keep ack at 0, and ignore req.
REQ-017 In FULL with out_ready high and req equal to 0, the module SHALL go to IDLE and set out_valid to 0; out_data and sel SHALL keep their last values.
REQ-018 In FULL with out_ready high and req nonzero, accept and reload SHALL happen on the same edge, giving one word per cycle with no bubble.
REQ-019 In IDLE with req equal to 0, the module SHALL change no state, and ack SHALL stay 0.
REQ-020 Latency: a request seen at edge N, with output space free, SHALL give out_valid and ack from edge N onward, one register stage.
REQ-021 A requester SHALL drop or change its word only after seeing its ack; the arbiter captures data on the ack edge only.
REQ-022 ack SHALL never have more than one bit set, and SHALL be 0 on every cycle without a load.

Reset
REQ-023 While rst_n is low, the module SHALL immediately force state IDLE, out_valid 0, ack 0, out_data 0, sel 0, and ptr 3, so that requester 0 has first priority.
REQ-024 Reset asserted mid-transfer SHALL discard the held word with no ack replay; the first load after rst_n deasserts SHALL follow REQ-015 from ptr 3.

Configuration
REQ-025 Macro MUX4_ARB_FIXED_PRIO_EN SHALL select the arbitration policy.
REQ-026 When the macro is defined, the lowest-numbered requesting index SHALL always win, ptr SHALL not be used, and all other behaviour SHALL be unchanged.
REQ-027 When the macro is undefined, the round-robin policy of REQ-015 SHALL apply.

Verification
REQ-028 Reset, then req=0001, data0=0x00000001, out_ready=1 -> one edge later: ack=0001, sel=0, out_data=0x00000001, out_valid=1; next edge with req=0: out_valid=0.
REQ-029 req=1111 held, data0..data3=0x1..0x4, out_ready=1, round robin -> ack sequence 0001, 0010, 0100, 1000, 0001; out_data 0x1, 0x2, 0x3, 0x4, 0x1 on consecutive cycles with no gap.
REQ-030 Backpressure: load 0x00000003 from requester 2, out_ready=0 for 5 cycles with req=1011 -> out_data stays 0x3, sel stays 2, ack stays 0; out_ready=1 -> requester 3 wins next (ack=1000).
REQ-031 Reset mid-FULL with out_data=0x00000004 -> out_valid=0, out_data=0 at once; after release with req=1100 -> requester 2 wins first.
REQ-032 With MUX4_ARB_FIXED_PRIO_EN defined, req=0110 held, out_ready=1 -> ack=0010 every cycle and requester 2 is never granted.
REQ-033 All scenarios: check every cycle that ack is zero or one-hot and that sel always equals the index of the last ack.

Source files
------------

// File: rtl/mux4_arbiter_if.sv
// Handshake/bus bundle between four requesters, the arbiter and its consumer.
// master = requester/consumer side, slave = arbiter side.
interface mux4_arbiter_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic [3:0]        req;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] data3;
  logic [3:0]        ack;
  logic [1:0]        sel;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output req, data0, data1, data2, data3, out_ready,
    input  ack, sel, out_data, out_valid
  );

  modport slave (
    input  req, data0, data1, data2, data3, out_ready,
    output ack, sel, out_data, out_valid
  );

endinterface

// File: rtl/mux4_arbiter.sv
// Four-requester arbiter feeding a single registered output slot (mux4 select on sel).
// Define MUX4_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round robin.
module mux4_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  mux4_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [3:0]        ack_q, ack_d;
  logic [1:0]        sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q;

  logic              any_req_c;
  logic              load_c;
  logic [1:0]        win_c;
  logic [DATA_W-1:0] win_data_c;

  assign any_req_c = |bus.req;
  // Output slot is free when empty, or when the held word leaves on this edge.
  assign load_c    = any_req_c && ((state_q == IDLE) || bus.out_ready);

`ifdef MUX4_ARB_FIXED_PRIO_EN
  // Lowest-numbered requester always wins.
  always_comb begin
    win_c = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) win_c = 2'(i);
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_c;
  logic       found_c;

  // Search upward from ptr+1 with wrap; k=4 lands back on ptr itself.
  always_comb begin
    win_c   = 2'd0;
    idx_c   = 2'd0;
    found_c = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx_c = ptr_q + 2'(k);
      if (!found_c && bus.req[idx_c]) begin
        win_c   = idx_c;
        found_c = 1'b1;
      end
    end
  end

  assign ptr_d = load_c ? win_c : ptr_q;

  // Reset to 3 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd3;
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    win_data_c = bus.data0;
    case (win_c)
      2'd0:    win_data_c = bus.data0;
      2'd1:    win_data_c = bus.data1;
      2'd2:    win_data_c = bus.data2;
      default: win_data_c = bus.data3;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    ack_d   = 4'b0000;
    sel_d   = sel_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (any_req_c) state_d = FULL;
      FULL: if (bus.out_ready) state_d = any_req_c ? FULL : IDLE;
      default: state_d = IDLE;
    endcase
    if (load_c) begin
      ack_d  = 4'b0001 << win_c;
      sel_d  = win_c;
      data_d = win_data_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 4'b0000;
      sel_q   <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= (state_d == FULL);
    end
  end

  assign bus.ack       = ack_q;
  assign bus.sel       = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

endmodule
